// File: rtl/afterburner2_ddr_interp.sv
// afterburner2_ddr_interp
// 2x half-band interpolator for a DDR DAC. Each clock it accepts one signed
// 17-bit sample. It produces two registered offset-binary words at gain 1/2:
// outd0 is the on-grid sample and outd1 is the mid-point sample.
module afterburner2_ddr_interp (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] ind,
  output logic [15:0] outd0,
  output logic [15:0] outd1
);

  localparam int W = 24;  // comfortably above the 22 bits the worst-case sum needs

  // tap[0] holds the most recent sample; tap[4] holds the oldest one.
  logic signed [16:0] tap [0:4];

  logic signed [W-1:0] e1, e2, e3, e4;
  logic signed [W-1:0] acc0, acc1;
  logic signed [W-1:0] y0, y1;

  // Clip a rounded result to 16-bit signed, then flip the MSB to offset binary.
  function automatic logic [15:0] sat_ob(input logic signed [W-1:0] v);
    logic [15:0] s;
    if (v > 24'sd32767)
      s = 16'h7FFF;
    else if (v < -24'sd32768)
      s = 16'h8000;
    else
      s = v[15:0];
    return s ^ 16'h8000;
  endfunction

  // Sign-extend the taps, apply the filter, and round half-up before the shift.
  always_comb begin
    e1   = W'(tap[1]);
    e2   = W'(tap[2]);
    e3   = W'(tap[3]);
    e4   = W'(tap[4]);
    acc0 = e3 + 24'sd1;
    acc1 = -e4 + 24'sd9 * e3 + 24'sd9 * e2 - e1 + 24'sd16;
    y0   = acc0 >>> 1;
    y1   = acc1 >>> 5;
  end

  // Sample delay line plus the output registers. Reset clears the history to zero.
  // NOTE: every register here is updated with <=, so each stage reads the value the previous stage held before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) tap[i] <= '0;
      outd0 <= 16'h8000;
      outd1 <= 16'h8000;
    end else begin
      tap[0] <= $signed(ind);
      for (int i = 1; i < 5; i++) tap[i] <= tap[i-1];
      outd0 <= sat_ob(y0);
      outd1 <= sat_ob(y1);
    end
  end

endmodule

// File: tb/tb_afterburner2_ddr_interp.sv
// Scoreboard bench for afterburner2_ddr_interp.
// The stimulus process drives one sample per clock. For each edge it pushes
// the expected output pair: a hand-computed constant for the directed phases,
// or the value of a reference model for the sine phases. A separate monitor
// pops one entry on each falling edge and compares it with the DUT outputs.
module tb_afterburner2_ddr_interp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] ind = '0;
  logic [15:0] outd0, outd1;

  afterburner2_ddr_interp dut (
    .clk   (clk),
    .rst   (rst),
    .ind   (ind),
    .outd0 (outd0),
    .outd1 (outd1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] e0;
    logic [15:0] e1;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   h[5] = '{0, 0, 0, 0, 0};  // model history: h[0] is the newest sample
  int   min0 = 65535, max0 = 0;   // extremes seen on outd0 during overdrive
  bit   track_od = 1'b0;

  // Round half-up, clip to 16-bit signed, and convert to offset binary.
  function automatic logic [15:0] code(input real v);
    int r;
    r = $rtoi($floor(v + 0.5));
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r) ^ 16'h8000;
  endfunction

  // Apply one sample and push the expected outputs after the following edge.
  // When use_model is set, the expectation comes from the reference model;
  // otherwise it comes from the hand-computed e0/e1 values.
  task automatic step(input bit r, input int v, input bit use_model,
                      input logic [15:0] e0, input logic [15:0] e1, input string tag);
    exp_t e;
    logic [15:0] m0, m1;
    m0 = code(h[3] / 2.0);
    m1 = code((-h[4] + 9 * h[3] + 9 * h[2] - h[1]) / 32.0);
    if (r) begin
      m0 = 16'h8000;
      m1 = 16'h8000;
      for (int i = 0; i < 5; i++) h[i] = 0;
    end else begin
      for (int i = 4; i > 0; i--) h[i] = h[i-1];
      h[0] = v;
    end
    rst = r;
    ind = 17'(v);
    @(posedge clk);
    e.e0  = use_model ? m0 : e0;
    e.e1  = use_model ? m1 : e1;
    e.tag = tag;
    q.push_back(e);
    #1;
  endtask

  // Sine sample for a given step; the result is clipped to the 17-bit input range.
  function automatic int sine(input real amp, input int i);
    real s;
    int  v;
    s = amp * $sin(2.0 * 3.14159265358979 * 11.0 * i / 196.0);
    v = $rtoi($floor(s + 0.5));
    if (v > 65535)  v = 65535;
    if (v < -65536) v = -65536;
    return v;
  endfunction

  // Monitor: on each falling edge, pop one expectation and compare it with the DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        n_checks++;
        if (outd0 !== e.e0) begin
          n_fail++;
          $display("FAIL %s outd0: got %h expected %h", e.tag, outd0, e.e0);
        end
        n_checks++;
        if (outd1 !== e.e1) begin
          n_fail++;
          $display("FAIL %s outd1: got %h expected %h", e.tag, outd1, e.e1);
        end
        if (track_od) begin
          if (int'(outd0) < min0) min0 = int'(outd0);
          if (int'(outd0) > max0) max0 = int'(outd0);
        end
      end
    end
  end

  initial begin
    int budget;

    // Reset held for 3 clocks with ind = 0, then released into silence.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 16'h8000, 16'h8000, "reset");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 16'h8000, 16'h8000, "post_reset");

    // Negative impulse: outd1 follows 31,-281,-281,31 and outd0 reaches -500 four edges later.
    step(0, -1000, 0, 16'h8000, 16'h8000, "imp_n0");
    step(0, 0,     0, 16'h8000, 16'h8000, "imp_n1");
    step(0, 0,     0, 16'h8000, 16'h801F, "imp_n2");
    step(0, 0,     0, 16'h8000, 16'h7EE7, "imp_n3");
    step(0, 0,     0, 16'h7E0C, 16'h7EE7, "imp_n4");
    step(0, 0,     0, 16'h8000, 16'h801F, "imp_n5");
    step(0, 0,     0, 16'h8000, 16'h8000, "imp_n6");

    // Positive impulse: outd1 follows -31,281,281,-31 and outd0 reaches +500.
    step(0, 1000, 0, 16'h8000, 16'h8000, "imp_p0");
    step(0, 0,    0, 16'h8000, 16'h8000, "imp_p1");
    step(0, 0,    0, 16'h8000, 16'h7FE1, "imp_p2");
    step(0, 0,    0, 16'h8000, 16'h8119, "imp_p3");
    step(0, 0,    0, 16'h81F4, 16'h8119, "imp_p4");
    step(0, 0,    0, 16'h8000, 16'h7FE1, "imp_p5");
    step(0, 0,    0, 16'h8000, 16'h8000, "imp_p6");

    // Rounding ties on outd0: 0.5 rounds up to 1, and -0.5 rounds up to 0.
    step(0, 1,  0, 16'h8000, 16'h8000, "tie_p0");
    step(0, -1, 0, 16'h8000, 16'h8000, "tie_n0");
    step(0, 0,  0, 16'h8000, 16'h8000, "tie_2");
    step(0, 0,  0, 16'h8000, 16'h8000, "tie_3");
    step(0, 0,  0, 16'h8001, 16'h8000, "tie_p4");
    step(0, 0,  0, 16'h8000, 16'h8000, "tie_n4");
    step(0, 0,  0, 16'h8000, 16'h8000, "tie_6");

    // Positive full-scale DC: the step overshoot on outd1 clips, then both outputs settle at 0xFFFF.
    step(0, 65535, 0, 16'h8000, 16'h8000, "dc_0");
    step(0, 65535, 0, 16'h8000, 16'h8000, "dc_1");
    step(0, 65535, 0, 16'h8000, 16'h7800, "dc_2");
    step(0, 65535, 0, 16'h8000, 16'hC000, "dc_3");
    step(0, 65535, 0, 16'hFFFF, 16'hFFFF, "dc_4");
    step(0, 65535, 0, 16'hFFFF, 16'hFFFF, "dc_5");
    step(0, 65535, 0, 16'hFFFF, 16'hFFFF, "dc_6");
    step(1, 65535, 0, 16'h8000, 16'h8000, "dc_rst");
    step(0, 0,     0, 16'h8000, 16'h8000, "dc_after_rst");

    // Full-scale coherent sine, checked against the reference model.
    for (int i = 0; i < 196; i++) step(0, sine(65535.0, i), 1, '0, '0, "sine");

    // Overdriven sine, clipped at the input to 17 bits.
    track_od = 1'b1;
    for (int i = 0; i < 196; i++) step(0, sine(75000.0, i), 1, '0, '0, "overdrive");
    step(0, -65536, 1, '0, '0, "od_min");
    step(0, -65536, 1, '0, '0, "od_min");
    step(0, -65536, 1, '0, '0, "od_min");
    step(0, -65536, 1, '0, '0, "od_min");
    step(0, -65536, 1, '0, '0, "od_min");
    step(0, 0, 1, '0, '0, "od_tail");

    // Reset asserted mid-sine, then recovery.
    for (int i = 0; i < 40; i++) step(0, sine(65535.0, i), 1, '0, '0, "pre_mid_rst");
    step(1, sine(65535.0, 40), 0, 16'h8000, 16'h8000, "mid_rst");
    for (int i = 41; i < 100; i++) step(0, sine(65535.0, i), 1, '0, '0, "post_mid_rst");

    // Drain the scoreboard, with a bound on how long to wait.
    budget = 10;
    while (q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    track_od = 1'b0;

    // During overdrive, outd0 must have pinned at both rails.
    n_checks++;
    if (min0 != 0 || max0 != 65535) begin
      n_fail++;
      $display("FAIL od_pin: outd0 min %h max %h, expected 0000 and ffff", min0, max0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
